// File: rtl/correlation_barker_stream_if.sv
// ---------------------------------------------------------------------------
// correlation_barker_stream_if
//   Bundles the 1-bit input stream and the scored output stream of the
//   correlator into one interface.
//
//   Signals
//     s_tdata   input bit                 (producer -> correlator)
//     s_tvalid  input valid               (producer -> correlator)
//     s_tlast   last bit of frame         (producer -> correlator)
//     s_tready  input ready               (correlator -> producer)
//     m_tdata   score, SCORE_W bits       (correlator -> consumer)
//     m_tuser   detect flag               (correlator -> consumer)
//     m_tlast   frame end for this beat   (correlator -> consumer)
//     m_tvalid  output valid              (correlator -> consumer)
//     m_tready  output ready              (consumer -> correlator)
//
//   Modports
//     slave  : the correlator's view
//     master : the surrounding logic (producer and consumer side)
// ---------------------------------------------------------------------------
interface correlation_barker_stream_if #(
  parameter int SCORE_W = 4
);
  logic               s_tdata;
  logic               s_tvalid;
  logic               s_tlast;
  logic               s_tready;
  logic [SCORE_W-1:0] m_tdata;
  logic               m_tuser;
  logic               m_tlast;
  logic               m_tvalid;
  logic               m_tready;

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    input  s_tlast,
    output s_tready,
    output m_tdata,
    output m_tuser,
    output m_tlast,
    output m_tvalid,
    input  m_tready
  );

  modport master (
    output s_tdata,
    output s_tvalid,
    output s_tlast,
    input  s_tready,
    input  m_tdata,
    input  m_tuser,
    input  m_tlast,
    input  m_tvalid,
    output m_tready
  );
endinterface

// File: rtl/correlation_barker_stream.sv
// ---------------------------------------------------------------------------
// correlation_barker_stream
//   Streaming sliding-window correlator for a 1-bit stream. Every accepted
//   input bit produces one output beat carrying the number of window bits
//   that agree with TARGET_SEQ, plus a detect flag once the window is full
//   and the mismatch count is within MAX_ERR. Windows never span frames:
//   an accepted beat with s_tlast clears the window after it is scored.
//
//   Ports
//     i_clk      clock
//     i_rst_n    synchronous active-low reset
//     bus        correlation_barker_stream_if.slave (input and output streams)
//     o_det_cnt  16-bit saturating detect counter (only with CORR_DET_CNT_EN)
//
//   Build option
//     CORR_DET_CNT_EN  when defined, adds o_det_cnt counting output transfers
//                      that carry a detect flag.
//
//   Timing: single output register, latency 1, full throughput. The only
//   combinational path across the block is m_tready -> s_tready.
// ---------------------------------------------------------------------------
module correlation_barker_stream #(
  parameter int                  SEQ_LEN    = 11,
  parameter logic [SEQ_LEN-1:0]  TARGET_SEQ = 11'b11100010010,
  parameter int                  MAX_ERR    = 0
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  correlation_barker_stream_if.slave   bus
`ifdef CORR_DET_CNT_EN
  ,
  output logic [15:0]                  o_det_cnt
`endif
);

  localparam int SCORE_W = $clog2(SEQ_LEN + 1);
  localparam logic [SCORE_W-1:0] SEQ_LEN_W = SCORE_W'(SEQ_LEN);
  localparam logic [SCORE_W-1:0] MAX_ERR_W = SCORE_W'(MAX_ERR);

  logic [SEQ_LEN-1:0] win_q,      win_d;
  logic [SCORE_W-1:0] fill_q,     fill_d;
  logic [SCORE_W-1:0] m_tdata_q,  m_tdata_d;
  logic               m_tuser_q,  m_tuser_d;
  logic               m_tlast_q,  m_tlast_d;
  logic               m_tvalid_q, m_tvalid_d;

  logic               s_tready;
  logic               accept;
  logic [SEQ_LEN-1:0] win_shift;
  logic [SEQ_LEN-1:0] diff;
  logic [SCORE_W-1:0] fill_inc;
  logic [SCORE_W-1:0] mism;
  logic [SCORE_W-1:0] score;
  logic               detect;

  // Ready is held low during reset so nothing is accepted on a reset edge.
  assign s_tready = i_rst_n && (!m_tvalid_q || bus.m_tready);
  assign accept   = bus.s_tvalid && s_tready;

  // Newest bit enters at bit 0; bit SEQ_LEN-1 holds the oldest bit.
  assign win_shift = {win_q[SEQ_LEN-2:0], bus.s_tdata};
  assign diff      = win_shift ^ TARGET_SEQ;
  assign fill_inc  = (fill_q == SEQ_LEN_W) ? fill_q : fill_q + SCORE_W'(1);

  always_comb begin
    mism = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      mism = mism + SCORE_W'(diff[i]);
    end
  end

  assign score  = SEQ_LEN_W - mism;
  // The fill gate suppresses detects on the first SEQ_LEN-1 beats of a frame,
  // where the zero-padded window could otherwise match a pattern with few ones.
  assign detect = (fill_inc == SEQ_LEN_W) && (mism <= MAX_ERR_W);

  always_comb begin
    win_d      = win_q;
    fill_d     = fill_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;

    if (accept) begin
      m_tdata_d  = score;
      m_tuser_d  = detect;
      m_tlast_d  = bus.s_tlast;
      m_tvalid_d = 1'b1;
      if (bus.s_tlast) begin
        // The last beat is scored with the full window above; only the
        // stored state restarts for the next frame.
        win_d  = '0;
        fill_d = '0;
      end else begin
        win_d  = win_shift;
        fill_d = fill_inc;
      end
    end else if (bus.m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      win_q      <= '0;
      fill_q     <= '0;
      m_tdata_q  <= '0;
      m_tuser_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      win_q      <= win_d;
      fill_q     <= fill_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign bus.s_tready = s_tready;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tuser  = m_tuser_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tvalid = m_tvalid_q;

`ifdef CORR_DET_CNT_EN
  logic [15:0] det_cnt_q, det_cnt_d;

  always_comb begin
    det_cnt_d = det_cnt_q;
    if (m_tvalid_q && bus.m_tready && m_tuser_q && (det_cnt_q != 16'hFFFF)) begin
      det_cnt_d = det_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      det_cnt_q <= '0;
    end else begin
      det_cnt_q <= det_cnt_d;
    end
  end

  assign o_det_cnt = det_cnt_q;
`endif

endmodule

// File: tb/tb_correlation_barker_stream.sv
// ---------------------------------------------------------------------------
// tb_correlation_barker_stream
//   Directed bench for the correlator. The main instance (defaults) is
//   checked every cycle against a frame-history model; two extra instances
//   cover MAX_ERR=1 and a 13-bit Barker pattern.
// ---------------------------------------------------------------------------
module tb_correlation_barker_stream;

  localparam int          SEQ   = 11;
  localparam int          MERR  = 0;
  localparam logic [63:0] PAT11 = 64'b11100010010;
  localparam logic [63:0] PAT13 = 64'b1111100110101;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  logic s_tdata  = 1'b0;
  logic s_tvalid = 1'b0;
  logic s_tlast  = 1'b0;
  logic m_rdy    = 1'b1;
  logic en_b     = 1'b0;
  logic en_c     = 1'b0;
  logic rdy_rand = 1'b0;
  logic [31:0] rdy_pat;
  int          rcyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  correlation_barker_stream_if #(.SCORE_W(4)) ifm ();
  correlation_barker_stream_if #(.SCORE_W(4)) ifb ();
  correlation_barker_stream_if #(.SCORE_W(4)) ifc ();

  assign ifm.s_tdata  = s_tdata;
  assign ifm.s_tvalid = s_tvalid;
  assign ifm.s_tlast  = s_tlast;
  assign ifm.m_tready = m_rdy;

  assign ifb.s_tdata  = s_tdata;
  assign ifb.s_tvalid = s_tvalid && en_b;
  assign ifb.s_tlast  = s_tlast;
  assign ifb.m_tready = 1'b1;

  assign ifc.s_tdata  = s_tdata;
  assign ifc.s_tvalid = s_tvalid && en_c;
  assign ifc.s_tlast  = s_tlast;
  assign ifc.m_tready = 1'b1;

`ifdef CORR_DET_CNT_EN
  logic [15:0] det_cnt_m, det_cnt_b, det_cnt_c;
  int          det_mdl = 0;
`endif

  correlation_barker_stream u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (ifm.slave)
`ifdef CORR_DET_CNT_EN
    , .o_det_cnt (det_cnt_m)
`endif
  );

  correlation_barker_stream #(.MAX_ERR(1)) u_dut_e1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (ifb.slave)
`ifdef CORR_DET_CNT_EN
    , .o_det_cnt (det_cnt_b)
`endif
  );

  correlation_barker_stream #(
    .SEQ_LEN    (13),
    .TARGET_SEQ (13'b1111100110101),
    .MAX_ERR    (0)
  ) u_dut_b13 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (ifc.slave)
`ifdef CORR_DET_CNT_EN
    , .o_det_cnt (det_cnt_c)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int d;
    bit u;
    bit l;
  } beat_t;

  logic [63:0] tgt_m = PAT11;
  bit          hist[$];
  beat_t       exp_q[$];
  int          log_d[$];
  bit          log_u[$];
  bit          log_l[$];
  int          logb_d[$];
  bit          logb_u[$];
  int          logc_d[$];
  bit          logc_u[$];
  int          stall_cnt = 0;
  bit          held_v = 1'b0;
  logic [5:0]  held_val;

  // Score = agreements between the last SEQ bits of the current frame
  // (older positions read as 0 until the frame has SEQ bits) and the target.
  function automatic beat_t model_beat(input bit d, input bit l);
    beat_t b;
    int    sc;
    bit    w;
    hist.push_back(d);
    sc = 0;
    for (int i = 0; i < SEQ; i++) begin
      w = (i < hist.size()) ? hist[hist.size() - 1 - i] : 1'b0;
      if (w == tgt_m[i]) sc++;
    end
    b.d = sc;
    b.u = (hist.size() >= SEQ) && ((SEQ - sc) <= MERR);
    b.l = l;
    if (l) hist.delete();
    else if (hist.size() > SEQ) void'(hist.pop_front());
    return b;
  endfunction

  // ---------------- compare process (main DUT) ----------------
  always @(negedge i_clk) begin
    beat_t e;
    if (!i_rst_n) begin
      exp_q.delete();
      hist.delete();
      held_v = 1'b0;
`ifdef CORR_DET_CNT_EN
      det_mdl = 0;
`endif
    end else begin
      chk("s_tready_rule", 64'(ifm.s_tready), 64'(!ifm.m_tvalid || m_rdy));
      chk("m_tvalid_pending", 64'(ifm.m_tvalid), 64'(exp_q.size() != 0));
      if (held_v && ifm.m_tvalid)
        chk("held_stable", 64'({ifm.m_tdata, ifm.m_tuser, ifm.m_tlast}), 64'(held_val));
`ifdef CORR_DET_CNT_EN
      chk("det_cnt", 64'(det_cnt_m), 64'(det_mdl));
`endif
      if (ifm.m_tvalid && m_rdy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_tdata", 64'(ifm.m_tdata), 64'(e.d));
        chk("m_tuser", 64'(ifm.m_tuser), 64'(e.u));
        chk("m_tlast", 64'(ifm.m_tlast), 64'(e.l));
        log_d.push_back(int'(ifm.m_tdata));
        log_u.push_back(ifm.m_tuser);
        log_l.push_back(ifm.m_tlast);
`ifdef CORR_DET_CNT_EN
        if (e.u && det_mdl < 65535) det_mdl++;
`endif
      end
      held_v   = ifm.m_tvalid && !m_rdy;
      held_val = {ifm.m_tdata, ifm.m_tuser, ifm.m_tlast};
      if (ifm.s_tvalid && !ifm.s_tready) stall_cnt++;
      if (ifm.s_tvalid && ifm.s_tready) exp_q.push_back(model_beat(ifm.s_tdata, ifm.s_tlast));
    end
  end

  // Side instances always accept output, so every valid cycle is a transfer.
  always @(negedge i_clk) begin
    if (i_rst_n && ifb.m_tvalid) begin
      logb_d.push_back(int'(ifb.m_tdata));
      logb_u.push_back(ifb.m_tuser);
    end
    if (i_rst_n && ifc.m_tvalid) begin
      logc_d.push_back(int'(ifc.m_tdata));
      logc_u.push_back(ifc.m_tuser);
    end
  end

  always begin
    @(posedge i_clk);
    #1;
    if (rdy_rand) begin
      m_rdy = rdy_pat[rcyc % 32];
      rcyc++;
    end else begin
      m_rdy = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input bit d, input bit l);
    int k;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    k = 0;
    @(negedge i_clk);
    while (!ifm.s_tready && k < 50) begin
      @(negedge i_clk);
      k++;
    end
    if (k >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: s_tready stuck low for %0d cycles, expected high", k);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_pat(input logic [63:0] p, input int n, input bit last_end, input int flip);
    for (int i = 0; i < n; i++)
      send(p[n-1-i] ^ (i == flip), last_end && (i == n - 1));
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tdata  = 1'($urandom);
    s_tlast  = 1'($urandom);
  endtask

  task automatic drain();
    int k;
    idle();
    k = 0;
    while ((exp_q.size() != 0 || ifm.m_tvalid) && k < 100) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still pending, expected 0", exp_q.size());
    end
    repeat (2) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic clr_logs();
    log_d.delete();  log_u.delete();  log_l.delete();
    logb_d.delete(); logb_u.delete();
    logc_d.delete(); logc_u.delete();
  endtask

  task automatic do_reset();
    idle();
    i_rst_n = 1'b0;
    repeat (2) begin
      @(posedge i_clk);
      #1;
    end
    i_rst_n = 1'b1;
  endtask

  function automatic int cnt1(input bit q[$]);
    int c = 0;
    foreach (q[i]) if (q[i]) c++;
    return c;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    logic [63:0] pat_v;
    rdy_pat = $urandom;
    rdy_pat[7:5] = 3'b000;
    rdy_pat[1]   = 1'b1;
    rdy_pat[12]  = 1'b1;
    pat_v = PAT11;

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_s_tready", 64'(ifm.s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(ifm.m_tvalid), 64'd0);
    chk("rst_m_tdata",  64'(ifm.m_tdata),  64'd0);
    chk("rst_m_tuser",  64'(ifm.m_tuser),  64'd0);
    chk("rst_m_tlast",  64'(ifm.m_tlast),  64'd0);
    i_rst_n = 1'b1;

    // 1: clean pattern, one frame
    clr_logs();
    send_pat(PAT11, 11, 1'b1, -1);
    drain();
    chk("t1_beats", 64'(log_d.size()), 64'd11);
    chk("t1_det_count", 64'(cnt1(log_u)), 64'd1);
    if (log_d.size() == 11) begin
      chk("t1_first_score", 64'(log_d[0]), 64'd5);
      chk("t1_last_score",  64'(log_d[10]), 64'd11);
      chk("t1_last_det",    64'(log_u[10]), 64'd1);
      chk("t1_last_tlast",  64'(log_l[10]), 64'd1);
      chk("t1_mid_tlast",   64'(log_l[9]), 64'd0);
    end

    // 2: one bit flipped (5th sent bit), MAX_ERR 0 vs 1
    clr_logs();
    en_b = 1'b1;
    send_pat(PAT11, 11, 1'b1, 4);
    drain();
    en_b = 1'b0;
    chk("t2_beats_e0", 64'(log_d.size()), 64'd11);
    chk("t2_beats_e1", 64'(logb_d.size()), 64'd11);
    if (log_d.size() == 11 && logb_d.size() == 11) begin
      chk("t2_e0_score", 64'(log_d[10]), 64'd10);
      chk("t2_e0_det",   64'(log_u[10]), 64'd0);
      chk("t2_e1_score", 64'(logb_d[10]), 64'd10);
      chk("t2_e1_det",   64'(logb_u[10]), 64'd1);
    end
    chk("t2_e1_det_count", 64'(cnt1(logb_u)), 64'd1);

    // 3: pattern split by tlast after 5 bits
    clr_logs();
    for (int i = 0; i < 11; i++) send(pat_v[10-i], (i == 4) || (i == 10));
    drain();
    chk("t3_beats", 64'(log_d.size()), 64'd11);
    chk("t3_no_det", 64'(cnt1(log_u)), 64'd0);
    if (log_d.size() == 11) begin
      chk("t3_frame1_last_tlast", 64'(log_l[4]), 64'd1);
      chk("t3_frame2_first_score", 64'(log_d[5]), 64'd6);
    end

    // 4: valid held high, irregular output ready with a 3-cycle stall
    clr_logs();
    stall_cnt = 0;
    rdy_rand = 1'b1;
    repeat (3) send_pat(PAT11, 11, 1'b1, -1);
    idle();
    rdy_rand = 1'b0;
    drain();
    chk("t4_beats", 64'(log_d.size()), 64'd33);
    chk("t4_det_count", 64'(cnt1(log_u)), 64'd3);
    chk("t4_stall_seen", 64'(stall_cnt > 0), 64'd1);

    // 5: reset after 6 bits, then a full pattern
    clr_logs();
    for (int i = 0; i < 6; i++) send(pat_v[10-i], 1'b0);
    do_reset();
    chk("t5_mvalid_after_rst", 64'(ifm.m_tvalid), 64'd0);
    clr_logs();
    send_pat(PAT11, 11, 1'b1, -1);
    drain();
    chk("t5_beats", 64'(log_d.size()), 64'd11);
    chk("t5_det_count", 64'(cnt1(log_u)), 64'd1);
    if (log_u.size() == 11) chk("t5_det_on_11th", 64'(log_u[10]), 64'd1);

    // 6: three back-to-back patterns without tlast, then 13-bit Barker
    do_reset();
    clr_logs();
    repeat (3) send_pat(PAT11, 11, 1'b0, -1);
    drain();
    chk("t6_beats", 64'(log_d.size()), 64'd33);
    chk("t6_det_count", 64'(cnt1(log_u)), 64'd3);
    if (log_u.size() == 33) chk("t6_det_at_22", 64'(log_u[21]), 64'd1);
`ifdef CORR_DET_CNT_EN
    chk("t6_o_det_cnt", 64'(det_cnt_m), 64'd3);
`endif
    clr_logs();
    en_c = 1'b1;
    send_pat(PAT13, 13, 1'b1, -1);
    drain();
    en_c = 1'b0;
    chk("t6_b13_beats", 64'(logc_d.size()), 64'd13);
    chk("t6_b13_det_count", 64'(cnt1(logc_u)), 64'd1);
    if (logc_d.size() == 13) begin
      chk("t6_b13_score", 64'(logc_d[12]), 64'd13);
      chk("t6_b13_det",   64'(logc_u[12]), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
